// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: arbitrates write/read bursts and auto-refresh, splitting bursts at row boundaries
// into single-row commands for the SDRAM command engine.
module sdram_burst_arbiter #(
  parameter int ROW_WIDTH   = 13,
  parameter int COL_WIDTH   = 9,
  parameter int BANK_WIDTH  = 2,
  parameter int NUM_WIDTH   = 10,
  parameter int REF_PERIOD  = 781,
  parameter int HADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_done,
  input  logic [HADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WIDTH-1:0]   wr_num,
  input  logic                   wr_request,
  output logic                   wr_allow,
  output logic                   wr_busy,
  input  logic [HADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_WIDTH-1:0]   rd_num,
  input  logic                   rd_request,
  output logic                   rd_allow,
  output logic                   rd_busy,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [1:0]             cmd_type,
  output logic [HADDR_WIDTH-1:0] cmd_addr,
  output logic [COL_WIDTH:0]     cmd_len,
  input  logic                   eng_beat,
  input  logic                   eng_done,
  output logic                   ref_overrun
);
  localparam int LW = COL_WIDTH + 1;
  localparam int RC = ROW_WIDTH + COL_WIDTH;
  localparam int MW = NUM_WIDTH > LW ? NUM_WIDTH : LW;
  localparam int TW = REF_PERIOD > 1 ? $clog2(REF_PERIOD) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, NEXT, REF_ISSUE, REF_WAIT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic ref_pend_q, ref_pend_d, ref_overrun_q, ref_overrun_d;
  logic wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic last_wr_q, last_wr_d, act_wr_q, act_wr_d, resume_q, resume_d;
  logic [HADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, cur_addr_q, cur_addr_d;
  logic [NUM_WIDTH-1:0] wr_num_q, wr_num_d, rd_num_q, rd_num_d, rem_q, rem_d;
  logic cmd_valid_q, cmd_valid_d;
  logic [1:0] cmd_type_q, cmd_type_d;
  logic [HADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [LW-1:0] cmd_len_q, cmd_len_d;
  logic tick, sel_wr;
  logic [HADDR_WIDTH-1:0] src_addr;
  logic [NUM_WIDTH-1:0] src_rem;
  logic [LW-1:0] space, seg_len;
  // In IDLE the segment is sized from the port being selected, otherwise from the in-flight burst.
  assign sel_wr   = wr_busy_q & (~rd_busy_q | ~last_wr_q);
  assign src_addr = state_q == IDLE ? (sel_wr ? wr_addr_q : rd_addr_q) : cur_addr_q;
  assign src_rem  = state_q == IDLE ? (sel_wr ? wr_num_q : rd_num_q) : rem_q;
  assign space    = {1'b1, {COL_WIDTH{1'b0}}} - {1'b0, src_addr[COL_WIDTH-1:0]};
  assign seg_len  = MW'(src_rem) < MW'(space) ? LW'(src_rem) : space;
  assign tick     = tmr_q == TW'(REF_PERIOD - 1);
  always_comb begin
    state_d = state_q;
    tmr_d = tick ? '0 : tmr_q + 1'b1;
    ref_pend_d = ref_pend_q | tick;
    ref_overrun_d = ref_overrun_q | (tick & ref_pend_q);
    wr_busy_d = wr_busy_q;
    rd_busy_d = rd_busy_q;
    last_wr_d = last_wr_q;
    act_wr_d = act_wr_q;
    resume_d = resume_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_num_d = wr_num_q;
    rd_num_d = rd_num_q;
    cur_addr_d = cur_addr_q;
    rem_d = rem_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d = cmd_type_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d = cmd_len_q;
    if (init_done & wr_request & ~wr_busy_q) begin
      wr_busy_d = 1'b1;
      wr_addr_d = wr_addr;
      wr_num_d = wr_num;
    end
    if (init_done & rd_request & ~rd_busy_q) begin
      rd_busy_d = 1'b1;
      rd_addr_d = rd_addr;
      rd_num_d = rd_num;
    end
    case (state_q)
      IDLE:
        if (ref_pend_q) begin
          state_d = REF_ISSUE;
          resume_d = 1'b0;
          cmd_valid_d = 1'b1;
          cmd_type_d = 2'b10;
          cmd_addr_d = '0;
          cmd_len_d = '0;
        end else if (wr_busy_q | rd_busy_q) begin
          last_wr_d = sel_wr;
          act_wr_d = sel_wr;
          if (src_rem == '0) begin
            if (sel_wr) wr_busy_d = 1'b0;
            else rd_busy_d = 1'b0;
          end else begin
            state_d = ISSUE;
            cur_addr_d = src_addr;
            rem_d = src_rem;
            cmd_valid_d = 1'b1;
            cmd_type_d = {1'b0, ~sel_wr};
            cmd_addr_d = src_addr;
            cmd_len_d = seg_len;
          end
        end
      ISSUE:
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d = WAIT_DONE;
        end
      WAIT_DONE:
        if (eng_done) begin
          cur_addr_d = {cur_addr_q[HADDR_WIDTH-1:RC], cur_addr_q[RC-1:0] + RC'(cmd_len_q)};
          rem_d = rem_q - NUM_WIDTH'(cmd_len_q);
          if (rem_q == NUM_WIDTH'(cmd_len_q)) begin
            state_d = IDLE;
            if (act_wr_q) wr_busy_d = 1'b0;
            else rd_busy_d = 1'b0;
          end else state_d = NEXT;
        end
      NEXT:
        if (ref_pend_q) begin
          state_d = REF_ISSUE;
          resume_d = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_type_d = 2'b10;
          cmd_addr_d = '0;
          cmd_len_d = '0;
        end else begin
          state_d = ISSUE;
          cmd_valid_d = 1'b1;
          cmd_type_d = {1'b0, ~act_wr_q};
          cmd_addr_d = cur_addr_q;
          cmd_len_d = seg_len;
        end
      REF_ISSUE:
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          ref_pend_d = tick;
          state_d = REF_WAIT;
        end
      REF_WAIT:
        if (eng_done) begin
          if (resume_q) begin
            state_d = ISSUE;
            cmd_valid_d = 1'b1;
            cmd_type_d = {1'b0, ~act_wr_q};
            cmd_addr_d = cur_addr_q;
            cmd_len_d = seg_len;
          end else state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q <= '0;
      ref_pend_q <= 1'b0;
      ref_overrun_q <= 1'b0;
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
      last_wr_q <= 1'b0;
      act_wr_q <= 1'b0;
      resume_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_num_q <= '0;
      rd_num_q <= '0;
      cur_addr_q <= '0;
      rem_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q <= 2'b00;
      cmd_addr_q <= '0;
      cmd_len_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      ref_pend_q <= ref_pend_d;
      ref_overrun_q <= ref_overrun_d;
      wr_busy_q <= wr_busy_d;
      rd_busy_q <= rd_busy_d;
      last_wr_q <= last_wr_d;
      act_wr_q <= act_wr_d;
      resume_q <= resume_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_num_q <= wr_num_d;
      rd_num_q <= rd_num_d;
      cur_addr_q <= cur_addr_d;
      rem_q <= rem_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q <= cmd_type_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q <= cmd_len_d;
    end
  end
  // Beat strobes stay combinational so requestor FIFO timing matches the engine's data cycle.
  assign wr_allow    = eng_beat & (state_q == WAIT_DONE) & act_wr_q;
  assign rd_allow    = eng_beat & (state_q == WAIT_DONE) & ~act_wr_q;
  assign wr_busy     = wr_busy_q;
  assign rd_busy     = rd_busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign ref_overrun = ref_overrun_q;
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter: directed bench with a behavioural command engine and a command log.
module tb_sdram_burst_arbiter;
  localparam int RP = 300;
  typedef struct packed {logic [1:0] t; logic [23:0] a; logic [9:0] l;} cmd_t;
  logic clk = 1'b0;
  logic rst_n, init_done;
  logic [23:0] wr_addr, rd_addr, cmd_addr;
  logic [9:0] wr_num, rd_num, cmd_len;
  logic wr_request, rd_request, wr_allow, rd_allow, wr_busy, rd_busy;
  logic cmd_valid, cmd_ready, eng_beat, eng_done, ref_overrun;
  logic [1:0] cmd_type;
  int n_cmp = 0, n_err = 0;
  int cyc, wr_cnt = 0, rd_cnt = 0, wr_fall = 0, rd_fall = 0, cv_cnt = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;
  cmd_t log_q[$];
  cmd_t nr[$];

  sdram_burst_arbiter #(.REF_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_addr(wr_addr), .wr_num(wr_num), .wr_request(wr_request), .wr_allow(wr_allow), .wr_busy(wr_busy),
    .rd_addr(rd_addr), .rd_num(rd_num), .rd_request(rd_request), .rd_allow(rd_allow), .rd_busy(rd_busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .eng_beat(eng_beat), .eng_done(eng_done), .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_allow) wr_cnt = wr_cnt + 1;
    if (rd_allow) rd_cnt = rd_cnt + 1;
    if (wr_prev && !wr_busy) wr_fall = wr_fall + 1;
    if (rd_prev && !rd_busy) rd_fall = rd_fall + 1;
    if (cmd_valid) cv_cnt = cv_cnt + 1;
    wr_prev = wr_busy;
    rd_prev = rd_busy;
  end

  // Engine model: accepts a command one cycle after valid, streams len beats (3 idle cycles for refresh), then done.
  initial begin
    int n;
    bit ab, is_ref;
    cmd_ready = 1'b0;
    eng_beat = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid) begin
        log_q.push_back({cmd_type, cmd_addr, cmd_len});
        is_ref = cmd_type == 2'b10;
        n = is_ref ? 3 : int'(cmd_len);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        ab = 1'b0;
        for (int i = 0; i < n && !ab; i++) begin
          eng_beat = !is_ref;
          @(posedge clk);
          #1;
          if (!rst_n) ab = 1'b1;
        end
        eng_beat = 1'b0;
        if (!ab) begin
          eng_done = 1'b1;
          @(posedge clk);
          #1 eng_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk(input int b, input int r, input int c);
    logic [1:0] bb = 2'(b);
    logic [12:0] rr = 13'(r);
    logic [8:0] cc = 9'(c);
    return {bb, rr, cc};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic req(input bit w, input bit r, input logic [23:0] wa, input logic [9:0] wn,
                     input logic [23:0] ra, input logic [9:0] rn);
    @(negedge clk);
    wr_addr = wa; wr_num = wn; wr_request = w;
    rd_addr = ra; rd_num = rn; rd_request = r;
    @(negedge clk);
    wr_request = 1'b0;
    rd_request = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((wr_busy || rd_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(wr_busy || rd_busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic collect(input int b);
    nr.delete();
    for (int i = b; i < log_q.size(); i++)
      if (log_q[i].t != 2'b10) nr.push_back(log_q[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int b, w0, r0, f0, c0, k;
    rst_n = 1'b0; init_done = 1'b0;
    wr_addr = '0; wr_num = '0; wr_request = 1'b0;
    rd_addr = '0; rd_num = '0; rd_request = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_busy", 32'(wr_busy), 0);
    check("rst_rd_busy", 32'(rd_busy), 0);
    check("rst_wr_allow", 32'(wr_allow), 0);
    check("rst_rd_allow", 32'(rd_allow), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_type", 32'(cmd_type), 0);
    check("rst_cmd_addr", 32'(cmd_addr), 0);
    check("rst_cmd_len", 32'(cmd_len), 0);
    check("rst_ref_overrun", 32'(ref_overrun), 0);
    rst_n = 1'b1;
    req(1, 0, mk(0, 0, 1), 4, 0, 0);
    check("noinit_wr_busy", 32'(wr_busy), 0);
    @(negedge clk);
    check("noinit_cmd_valid", 32'(cmd_valid), 0);
    init_done = 1'b1;

    b = log_q.size(); w0 = wr_cnt; f0 = wr_fall;
    req(1, 0, mk(0, 0, 0), 256, 0, 0);
    check("w1_busy_t1", 32'(wr_busy), 1);
    check("w1_valid_t1", 32'(cmd_valid), 0);
    @(negedge clk);
    check("w1_valid_t2", 32'(cmd_valid), 1);
    check("w1_type", 32'(cmd_type), 0);
    check("w1_addr", 32'(cmd_addr), 0);
    check("w1_len", 32'(cmd_len), 256);
    req(1, 0, mk(0, 9, 9), 5, 0, 0);
    k = 0;
    while (!(eng_done && wr_cnt - w0 == 256) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("w1_done_seen", 32'(eng_done), 1);
    check("w1_busy_at_done", 32'(wr_busy), 1);
    @(negedge clk);
    check("w1_busy_after_done", 32'(wr_busy), 0);
    wait_idle("w1");
    collect(b);
    check("w1_ncmd", nr.size(), 1);
    check("w1_log_type", 32'(nr[0].t), 0);
    check("w1_log_addr", 32'(nr[0].a), 0);
    check("w1_log_len", 32'(nr[0].l), 256);
    check("w1_beats", wr_cnt - w0, 256);
    check("w1_falls", wr_fall - f0, 1);

    b = log_q.size(); r0 = rd_cnt; f0 = rd_fall;
    req(0, 1, 0, 0, mk(1, 5, 384), 256);
    wait_idle("r1");
    collect(b);
    check("r1_ncmd", nr.size(), 2);
    check("r1_s0_type", 32'(nr[0].t), 1);
    check("r1_s0_addr", 32'(nr[0].a), 32'(mk(1, 5, 384)));
    check("r1_s0_len", 32'(nr[0].l), 128);
    check("r1_s1_addr", 32'(nr[1].a), 32'(mk(1, 6, 0)));
    check("r1_s1_len", 32'(nr[1].l), 128);
    check("r1_beats", rd_cnt - r0, 256);
    check("r1_falls", rd_fall - f0, 1);

    do_reset();
    for (int p = 0; p < 2; p++) begin
      b = log_q.size();
      req(1, 1, mk(0, 1, 0), 4, mk(0, 2, 0), 4);
      check($sformatf("pair%0d_wr_busy", p), 32'(wr_busy), 1);
      check($sformatf("pair%0d_rd_busy", p), 32'(rd_busy), 1);
      wait_idle($sformatf("pair%0d", p));
      collect(b);
      check($sformatf("pair%0d_ncmd", p), nr.size(), 2);
      check($sformatf("pair%0d_first", p), 32'(nr[0].t), 0);
      check($sformatf("pair%0d_second", p), 32'(nr[1].t), 1);
    end

    k = 0;
    while (!(cyc % RP == 100 && !wr_busy && !rd_busy && !cmd_valid) && k < 2 * RP) begin
      @(negedge clk);
      k++;
    end
    check("ref_align", 32'(cyc % RP), 100);
    b = log_q.size(); w0 = wr_cnt; f0 = wr_fall;
    req(1, 0, mk(0, 3, 256), 400, 0, 0);
    wait_idle("ref");
    check("ref_nlog", log_q.size() - b, 3);
    check("ref_s0_type", 32'(log_q[b].t), 0);
    check("ref_s0_addr", 32'(log_q[b].a), 32'(mk(0, 3, 256)));
    check("ref_s0_len", 32'(log_q[b].l), 256);
    check("ref_mid_type", 32'(log_q[b+1].t), 2);
    check("ref_mid_len", 32'(log_q[b+1].l), 0);
    check("ref_s1_type", 32'(log_q[b+2].t), 0);
    check("ref_s1_addr", 32'(log_q[b+2].a), 32'(mk(0, 4, 0)));
    check("ref_s1_len", 32'(log_q[b+2].l), 144);
    check("ref_beats", wr_cnt - w0, 400);
    check("ref_falls", wr_fall - f0, 1);

    b = log_q.size(); r0 = rd_cnt;
    req(0, 1, 0, 0, mk(2, 8191, 500), 20);
    wait_idle("wrap");
    collect(b);
    check("wrap_ncmd", nr.size(), 2);
    check("wrap_s0_addr", 32'(nr[0].a), 32'(mk(2, 8191, 500)));
    check("wrap_s0_len", 32'(nr[0].l), 12);
    check("wrap_s1_addr", 32'(nr[1].a), 32'(mk(2, 0, 0)));
    check("wrap_s1_len", 32'(nr[1].l), 8);
    check("wrap_beats", rd_cnt - r0, 20);

    w0 = wr_cnt;
    req(1, 0, mk(0, 0, 0), 256, 0, 0);
    k = 0;
    while (wr_cnt - w0 < 10 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("abort_started", 32'(wr_cnt - w0 >= 10), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_wr_busy", 32'(wr_busy), 0);
    check("abort_wr_allow", 32'(wr_allow), 0);
    check("abort_cmd_valid", 32'(cmd_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b = log_q.size(); w0 = wr_cnt; f0 = wr_fall;
    req(1, 0, mk(0, 7, 0), 256, 0, 0);
    wait_idle("post");
    collect(b);
    check("post_ncmd", nr.size(), 1);
    check("post_len", 32'(nr[0].l), 256);
    check("post_beats", wr_cnt - w0, 256);
    check("post_falls", wr_fall - f0, 1);

    do_reset();
    b = log_q.size(); c0 = cv_cnt;
    req(1, 0, mk(0, 1, 1), 0, 0, 0);
    check("zero_busy_t1", 32'(wr_busy), 1);
    @(negedge clk);
    check("zero_busy_t2", 32'(wr_busy), 0);
    repeat (3) @(negedge clk);
    check("zero_no_valid", cv_cnt - c0, 0);
    check("zero_nlog", log_q.size() - b, 0);
    check("end_overrun", 32'(ref_overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
